// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data RAM, memory-mapped timer/LED/switch/systick
// peripherals, and the registered write-back bundle handed to WB.
module mem_stage #(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_MemWr,
  input  logic        Mem_MemRd,
  input  logic [31:0] Mem_in,
  input  logic [31:0] Mem_BusB,
  input  logic [31:0] Mem_PC,
  input  logic [1:0]  Mem_MemtoReg,
  input  logic [4:0]  Mem_WrReg,
  input  logic        Mem_RegWr,
  input  logic [7:0]  switch,
  output logic        WB_RegWr,
  output logic [4:0]  WB_WrReg,
  output logic [31:0] WB_WrData,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    IO_TH      = 3'd0,
    IO_TL      = 3'd1,
    IO_TCON    = 3'd2,
    IO_LED     = 3'd3,
    IO_SWITCH  = 3'd4,
    IO_SYSTICK = 3'd5
  } io_sel_e;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_th;
  logic [31:0]   r_tl;
  logic [2:0]    r_tcon;
  logic [7:0]    r_led;
  logic [31:0]   r_systick;

  logic          w_ram_hit;
  logic [AW-1:0] w_idx;
  logic          w_io_hit;
  io_sel_e       w_io_sel;
  logic          w_we_th, w_we_tl, w_we_tcon, w_we_led;
  logic          w_ovf;
  logic          w_irq_set;
  logic [31:0]   w_rd_data;
  logic [31:0]   w_load;
  logic [31:0]   w_wb_data;
  logic          w_unused_ok;

  assign w_ram_hit   = (Mem_in[31:AW+2] == '0);
  assign w_idx       = Mem_in[AW+1:2];
  assign w_io_hit    = (Mem_in[31:5] == 27'h200_0000);
  assign w_io_sel    = io_sel_e'(Mem_in[4:2]);
  assign w_unused_ok = ^Mem_in[1:0];

  assign w_we_th   = Mem_MemWr && w_io_hit && (w_io_sel == IO_TH);
  assign w_we_tl   = Mem_MemWr && w_io_hit && (w_io_sel == IO_TL);
  assign w_we_tcon = Mem_MemWr && w_io_hit && (w_io_sel == IO_TCON);
  assign w_we_led  = Mem_MemWr && w_io_hit && (w_io_sel == IO_LED);

  assign w_ovf     = r_tcon[0] && (r_tl == '1);
  assign w_irq_set = w_ovf && r_tcon[1];

  always_comb begin
    w_rd_data = '0;
    if (w_ram_hit) begin
      w_rd_data = r_ram[w_idx];
    end else if (w_io_hit) begin
      case (w_io_sel)
        IO_TH:      w_rd_data = r_th;
        IO_TL:      w_rd_data = r_tl;
        IO_TCON:    w_rd_data = {29'd0, r_tcon};
        IO_LED:     w_rd_data = {24'd0, r_led};
        IO_SWITCH:  w_rd_data = {24'd0, switch};
        IO_SYSTICK: w_rd_data = r_systick;
        default:    w_rd_data = '0;
      endcase
    end
  end

  assign w_load = Mem_MemRd ? w_rd_data : '0;

  always_comb begin
    case (Mem_MemtoReg)
      2'b01:   w_wb_data = w_load;
      2'b10:   w_wb_data = Mem_PC;
      default: w_wb_data = Mem_in;
    endcase
  end

  // RAM has no reset so stored data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (Mem_MemWr && w_ram_hit) begin
      r_ram[w_idx] <= Mem_BusB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_led     <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_we_th) begin
        r_th <= Mem_BusB;
      end
      if (w_we_tl) begin
        r_tl <= Mem_BusB;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (r_tcon[0]) begin
        r_tl <= r_tl + 32'd1;
      end
      // An overflow setting the status bit beats a software clear in the same cycle.
      if (w_we_tcon) begin
        r_tcon <= {Mem_BusB[2] | w_irq_set, Mem_BusB[1:0]};
      end else if (w_irq_set) begin
        r_tcon[2] <= 1'b1;
      end
      if (w_we_led) begin
        r_led <= Mem_BusB[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_RegWr  <= 1'b0;
      WB_WrReg  <= '0;
      WB_WrData <= '0;
    end else begin
      WB_RegWr  <= Mem_RegWr;
      WB_WrReg  <= Mem_WrReg;
      WB_WrData <= w_wb_data;
    end
  end

  assign led = r_led;
  assign irq = r_tcon[2];

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected WB bundles are queued as each
// operation is driven and compared one edge later.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        Mem_MemWr, Mem_MemRd;
  logic [31:0] Mem_in, Mem_BusB, Mem_PC;
  logic [1:0]  Mem_MemtoReg;
  logic [4:0]  Mem_WrReg;
  logic        Mem_RegWr;
  logic [7:0]  switch;
  logic        WB_RegWr;
  logic [4:0]  WB_WrReg;
  logic [31:0] WB_WrData;
  logic [7:0]  led;
  logic        irq;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  logic [37:0] exp_q[$];

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  mem_stage #(.RAM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .Mem_MemWr(Mem_MemWr), .Mem_MemRd(Mem_MemRd),
    .Mem_in(Mem_in), .Mem_BusB(Mem_BusB), .Mem_PC(Mem_PC),
    .Mem_MemtoReg(Mem_MemtoReg), .Mem_WrReg(Mem_WrReg), .Mem_RegWr(Mem_RegWr),
    .switch(switch),
    .WB_RegWr(WB_RegWr), .WB_WrReg(WB_WrReg), .WB_WrData(WB_WrData),
    .led(led), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent cycle count since reset release: the SYSTICK reference.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one MEM-stage operation, queue the expected WB bundle, compare after the edge.
  task automatic mem_op(input string tag, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] m2r, input logic [31:0] pc,
                        input logic [4:0] wreg, input logic rw,
                        input logic [31:0] exp_data);
    logic [37:0] e;
    Mem_MemWr    = wr;
    Mem_MemRd    = rd;
    Mem_in       = addr;
    Mem_BusB     = data;
    Mem_MemtoReg = m2r;
    Mem_PC       = pc;
    Mem_WrReg    = wreg;
    Mem_RegWr    = rw;
    exp_q.push_back({rw, wreg, exp_data});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".regwr"}, {31'd0, WB_RegWr}, {31'd0, e[37]});
      check({tag, ".wrreg"}, {27'd0, WB_WrReg}, {27'd0, e[36:32]});
      check({tag, ".data"},  WB_WrData, e[31:0]);
    end
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] data);
    mem_op(tag, 1'b1, 1'b0, addr, data, 2'b00, 32'd0, 5'd0, 1'b0, addr);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
    mem_op(tag, 1'b0, 1'b1, addr, 32'd0, 2'b01, 32'd0, 5'd3, 1'b1, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Mem_MemWr = 0; Mem_MemRd = 0; Mem_in = '0; Mem_BusB = '0; Mem_PC = '0;
    Mem_MemtoReg = 2'b00; Mem_WrReg = '0; Mem_RegWr = 0; switch = 8'h3C;
    #2;
    check("rst.regwr", {31'd0, WB_RegWr}, 32'd0);
    check("rst.data",  WB_WrData, 32'd0);
    check("rst.led",   {24'd0, led}, 32'd0);
    check("rst.irq",   {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // RAM store / load, low address bits ignored, RAM boundary
    st("st10", 32'h10, 32'hDEAD_BEEF);
    mem_op("ld10", 1'b0, 1'b1, 32'h10, 32'd0, 2'b01, 32'd0, 5'd8, 1'b1, 32'hDEAD_BEEF);
    ld("ld13", 32'h13, 32'hDEAD_BEEF);
    st("st3fc", 32'h3FC, 32'hCAFE_F00D);
    ld("ld3fc", 32'h3FC, 32'hCAFE_F00D);
    ld("ld400", 32'h400, 32'h0);
    mem_op("rdwr10", 1'b1, 1'b1, 32'h10, 32'h1111_1111, 2'b01, 32'd0, 5'd4, 1'b1, 32'hDEAD_BEEF);
    ld("ld10b", 32'h10, 32'h1111_1111);
    mem_op("alu11", 1'b0, 1'b0, 32'h1234, 32'd0, 2'b11, 32'd0, 5'd9, 1'b1, 32'h1234);
    mem_op("nord", 1'b0, 1'b0, 32'h10, 32'd0, 2'b01, 32'd0, 5'd9, 1'b1, 32'h0);
    mem_op("pc", 1'b0, 1'b0, 32'h20, 32'd0, 2'b10, 32'h0040_0008, 5'd31, 1'b1, 32'h0040_0008);

    // LED / switch / unmapped
    st("stled", A_LED, 32'h1A5);
    check("led", {24'd0, led}, 32'hA5);
    ld("ldsw", A_SW, 32'h3C);
    ld("ldled", A_LED, 32'hA5);
    ld("ldunmap", 32'h5000_0000, 32'h0);
    st("stunmap", 32'h5000_0000, 32'h1);
    ld("ldunmap2", 32'h5000_0000, 32'h0);

    // SYSTICK free-running, writes ignored
    ld("tick0", A_TICK, cyc);
    st("sttick", A_TICK, 32'h0);
    ld("tick1", A_TICK, cyc);

    // Timer overflow reloads TL from TH and raises irq
    st("stth", A_TH, 32'hFFFF_FFF0);
    st("sttl", A_TL, 32'hFFFF_FFFE);
    st("sttcon", A_TCON, 32'h3);
    ld("tl_fe", A_TL, 32'hFFFF_FFFE);
    check("irq_pre", {31'd0, irq}, 32'd0);
    ld("tl_ff", A_TL, 32'hFFFF_FFFF);
    check("irq_ovf", {31'd0, irq}, 32'd1);
    ld("tcon7", A_TCON, 32'h7);
    ld("tl_f1", A_TL, 32'hFFFF_FFF1);
    ld("th", A_TH, 32'hFFFF_FFF0);

    // Software TL write beats increment; irq set beats clear on overflow
    st("sttl_ff", A_TL, 32'hFFFF_FFFF);
    st("tcon_ovf", A_TCON, 32'h3);
    check("irq_keep", {31'd0, irq}, 32'd1);
    ld("tl_reload", A_TL, 32'hFFFF_FFF0);
    ld("tcon7b", A_TCON, 32'h7);
    st("tcon_clr", A_TCON, 32'h3);
    check("irq_clr", {31'd0, irq}, 32'd0);
    ld("tcon3", A_TCON, 32'h3);

    // Async reset mid-count with irq pending
    st("sttl_ff2", A_TL, 32'hFFFF_FFFF);
    mem_op("idle", 1'b0, 1'b0, 32'h0, 32'd0, 2'b00, 32'd0, 5'd0, 1'b0, 32'h0);
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
    mem_op("ldwb", 1'b0, 1'b1, 32'h3FC, 32'd0, 2'b01, 32'd0, 5'd31, 1'b1, 32'hCAFE_F00D);
    #2 reset = 1'b1;
    #1;
    check("arst.regwr", {31'd0, WB_RegWr}, 32'd0);
    check("arst.wrreg", {27'd0, WB_WrReg}, 32'd0);
    check("arst.data",  WB_WrData, 32'd0);
    check("arst.irq",   {31'd0, irq}, 32'd0);
    check("arst.led",   {24'd0, led}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    ld("post.tick", A_TICK, cyc);
    ld("post.tl", A_TL, 32'h0);
    ld("post.tcon", A_TCON, 32'h0);
    ld("post.tl2", A_TL, 32'h0);
    ld("post.th", A_TH, 32'h0);
    ld("post.ram3fc", 32'h3FC, 32'hCAFE_F00D);
    ld("post.ram10", 32'h10, 32'h1111_1111);
    ld("post.led", A_LED, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
